// File: rtl/cipher_link_pkg.sv
// Shared types and constants for the UART <-> 3-Way cipher link controller.
package cipher_link_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BLOCK_BYTES = 12;
    localparam int unsigned BLOCK_W     = BLOCK_BYTES * BYTE_W;
    localparam int unsigned CNT_W       = $clog2(BLOCK_BYTES);

    localparam logic [BYTE_W-1:0] HDR_KEY = 8'h4B;
    localparam logic [BYTE_W-1:0] HDR_ENC = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
        RX_KEY,
        RX_DATA,
        ISSUE,
        KEY_WAIT
    } rx_state_e;

    // Saturating increment for the 8-bit error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cipher_link_if.sv
// Valid/ready stream bundle used for both the byte links and the block links.
interface cipher_link_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/block_serializer.sv
// Unpacks one 96-bit cipher result into 12 bytes, most significant byte first.
module block_serializer
    import cipher_link_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BLOCK_W-1:0] i_s_tdata,
    input  logic               i_s_tvalid,
    output logic               o_s_tready,
    output logic [BYTE_W-1:0]  o_m_tdata,
    output logic               o_m_tvalid,
    input  logic               i_m_tready,
    output logic               o_empty
);

    logic [BLOCK_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_full;

    // Capture when empty, then shift out one byte per accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
        end else if (!r_full) begin
            if (i_s_tvalid) begin
                r_shift <= i_s_tdata;
                r_cnt   <= '0;
                r_full  <= 1'b1;
            end
        end else if (i_m_tready) begin
            r_shift <= {r_shift[BLOCK_W-BYTE_W-1:0], BYTE_W'(0)};
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(BLOCK_BYTES - 1)) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_s_tready = !r_full;
    assign o_m_tvalid = r_full;
    assign o_m_tdata  = r_shift[BLOCK_W-1 -: BYTE_W];
    assign o_empty    = !r_full;

endmodule

// File: rtl/cipher_link_ctrl.sv
// Frames UART commands into cipher blocks, owns the key register and returns
// cipher results to the UART as a byte stream.
module cipher_link_ctrl
    import cipher_link_pkg::*;
#(
    parameter logic [BLOCK_W-1:0] KEY_RESET      = 96'h0123456789ABCDEF11112222,
    parameter int unsigned        MAX_INFLIGHT   = 8,
    parameter int unsigned        TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    cipher_link_if.slave       s_uart,
    cipher_link_if.master      m_cipher,
    cipher_link_if.slave       s_cipher,
    cipher_link_if.master      m_uart,
    output logic [BLOCK_W-1:0] key,
    output logic               busy,
    output logic [7:0]         err_cnt
);

    localparam int unsigned IF_W = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    rx_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [TO_W-1:0]    r_to;
    logic [IF_W-1:0]    r_inflight;
    logic [BLOCK_W-1:0] r_blk;
    logic [BLOCK_W-1:0] r_key;
    logic [7:0]         r_err;
    logic               r_s_tready;
    logic               r_m_valid;

    logic               w_rx_hs;
    logic               w_issue_hs;
    logic               w_ret_hs;
    logic               w_to_hit;
    logic               w_last_byte;
    logic               w_room;
    logic [IF_W-1:0]    w_inflight_nxt;
    logic               w_ser_tready;
    logic               w_ser_empty;
    logic [BYTE_W-1:0]  w_tx_data;
    logic               w_tx_valid;

    assign w_rx_hs     = s_uart.tvalid && r_s_tready;
    assign w_issue_hs  = r_m_valid && m_cipher.tready;
    assign w_ret_hs    = s_cipher.tvalid && w_ser_tready;
    assign w_last_byte = (r_cnt == CNT_W'(BLOCK_BYTES - 1));
    assign w_to_hit    = (TIMEOUT_CYCLES != 0) && (r_to == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_issue_hs && !w_ret_hs) begin
            w_inflight_nxt = r_inflight + IF_W'(1);
        end else if (!w_issue_hs && w_ret_hs) begin
            w_inflight_nxt = r_inflight - IF_W'(1);
        end
    end

    // Room is judged on next-cycle occupancy so a returning result frees a slot at once.
    assign w_room = (w_inflight_nxt < IF_W'(MAX_INFLIGHT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_to       <= '0;
            r_blk      <= '0;
            r_key      <= KEY_RESET;
            r_err      <= '0;
            r_s_tready <= 1'b0;
            r_m_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_to       <= '0;
                    r_s_tready <= 1'b1;
                    if (w_rx_hs) begin
                        r_cnt <= '0;
                        if (s_uart.tdata == HDR_KEY) begin
                            r_state <= RX_KEY;
                        end else if (s_uart.tdata == HDR_ENC) begin
                            r_state <= RX_DATA;
                        end else begin
                            r_err <= sat_inc8(r_err);
                        end
                    end
                end
                RX_KEY, RX_DATA: begin
                    if (w_rx_hs) begin
                        r_to  <= '0;
                        r_blk <= {r_blk[BLOCK_W-BYTE_W-1:0], s_uart.tdata};
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last_byte) begin
                            r_s_tready <= 1'b0;
                            if (r_state == RX_KEY) begin
                                r_state <= KEY_WAIT;
                            end else begin
                                r_state   <= ISSUE;
                                r_m_valid <= w_room;
                            end
                        end
                    end else if (w_to_hit) begin
                        r_state <= IDLE;
                        r_to    <= '0;
                        r_err   <= sat_inc8(r_err);
                    end else begin
                        r_to <= r_to + TO_W'(1);
                    end
                end
                ISSUE: begin
                    if (w_issue_hs) begin
                        r_state    <= IDLE;
                        r_m_valid  <= 1'b0;
                        r_s_tready <= 1'b1;
                    end else begin
                        r_m_valid <= w_room;
                    end
                end
                KEY_WAIT: begin
                    if ((r_inflight == '0) && w_ser_empty) begin
                        r_key      <= r_blk;
                        r_state    <= IDLE;
                        r_s_tready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_m_valid  <= 1'b0;
                    r_s_tready <= 1'b1;
                end
            endcase
        end
    end

    block_serializer u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_s_tdata  (s_cipher.tdata),
        .i_s_tvalid (s_cipher.tvalid),
        .o_s_tready (w_ser_tready),
        .o_m_tdata  (w_tx_data),
        .o_m_tvalid (w_tx_valid),
        .i_m_tready (m_uart.tready),
        .o_empty    (w_ser_empty)
    );

    assign s_uart.tready   = r_s_tready;
    assign m_cipher.tvalid = r_m_valid;
    assign m_cipher.tdata  = r_blk;
    assign s_cipher.tready = w_ser_tready;
    assign m_uart.tdata    = w_tx_data;
    assign m_uart.tvalid   = w_tx_valid;
    assign key             = r_key;
    assign err_cnt         = r_err;
    assign busy            = (r_state != IDLE) || !w_ser_empty;

endmodule

// File: tb/tb_cipher_link_ctrl.sv
// Directed bench for cipher_link_ctrl with MAX_INFLIGHT=2 and TIMEOUT_CYCLES=16.
module tb_cipher_link_ctrl;
    import cipher_link_pkg::*;

    localparam logic [95:0] KEY_RST = 96'h0123456789ABCDEF11112222;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cipher_link_if #(.W(8))  u_s_uart   ();
    cipher_link_if #(.W(96)) u_m_cipher ();
    cipher_link_if #(.W(96)) u_s_cipher ();
    cipher_link_if #(.W(8))  u_m_uart   ();

    logic [95:0] w_key;
    logic        w_busy;
    logic [7:0]  w_err;

    cipher_link_ctrl #(
        .KEY_RESET      (KEY_RST),
        .MAX_INFLIGHT   (2),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_uart   (u_s_uart),
        .m_cipher (u_m_cipher),
        .s_cipher (u_s_cipher),
        .m_uart   (u_m_uart),
        .key      (w_key),
        .busy     (w_busy),
        .err_cnt  (w_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 96'(obs), 96'(exp));
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic hs;
        hs = 1'b0;
        u_s_uart.tdata  = b;
        u_s_uart.tvalid = 1'b1;
        for (int i = 0; i < 64 && !hs; i++) begin
            hs = u_s_uart.tready;
            tick();
        end
        u_s_uart.tvalid = 1'b0;
        chk1("rx_accept", hs, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [95:0] blk);
        send_byte(hdr);
        for (int i = 0; i < 12; i++) begin
            send_byte(blk[95 - 8*i -: 8]);
        end
    endtask

    task automatic return_result(input logic [95:0] blk);
        logic hs;
        hs = 1'b0;
        u_s_cipher.tdata  = blk;
        u_s_cipher.tvalid = 1'b1;
        for (int i = 0; i < 200 && !hs; i++) begin
            hs = u_s_cipher.tready;
            tick();
        end
        u_s_cipher.tvalid = 1'b0;
        chk1("ret_accept", hs, 1'b1);
    endtask

    initial begin
        int          got;
        logic        hs;
        logic [7:0]  b;
        logic [7:0]  eb;

        rst_n             = 1'b0;
        u_s_uart.tdata    = '0;
        u_s_uart.tvalid   = 1'b0;
        u_m_cipher.tready = 1'b0;
        u_s_cipher.tdata  = '0;
        u_s_cipher.tvalid = 1'b0;
        u_m_uart.tready   = 1'b0;
        tick();
        tick();

        // Reset state
        chk1("rst_s_uart_rdy",  u_s_uart.tready,   1'b0);
        chk1("rst_m_cipher_v",  u_m_cipher.tvalid, 1'b0);
        chk1("rst_m_uart_v",    u_m_uart.tvalid,   1'b0);
        chk1("rst_s_cipher_rdy", u_s_cipher.tready, 1'b1);
        chk ("rst_key",  w_key, KEY_RST);
        chk1("rst_busy", w_busy, 1'b0);
        chk ("rst_err",  96'(w_err), 96'd0);
        rst_n = 1'b1;
        tick();
        chk1("rdy_after_rst", u_s_uart.tready, 1'b1);

        // Encrypt frame packing and issue
        send_frame(8'h45, 96'h000102030405060708090A0B);
        chk1("enc_valid", u_m_cipher.tvalid, 1'b1);
        chk ("enc_data",  u_m_cipher.tdata, 96'h000102030405060708090A0B);
        chk1("enc_rx_rdy", u_s_uart.tready, 1'b0);
        chk1("enc_busy",  w_busy, 1'b1);
        tick();
        tick();
        chk1("enc_hold_v", u_m_cipher.tvalid, 1'b1);
        chk ("enc_hold_d", u_m_cipher.tdata, 96'h000102030405060708090A0B);
        u_m_cipher.tready = 1'b1;
        tick();
        u_m_cipher.tready = 1'b0;
        chk1("enc_done_v",   u_m_cipher.tvalid, 1'b0);
        chk1("enc_done_rdy", u_s_uart.tready, 1'b1);
        chk1("enc_done_busy", w_busy, 1'b0);

        // Result loopback with tready stalls every other cycle
        u_s_cipher.tdata  = 96'hA0A1A2A3A4A5A6A7A8A9AAAB;
        u_s_cipher.tvalid = 1'b1;
        tick();
        u_s_cipher.tvalid = 1'b0;
        chk1("lb_tx_v",    u_m_uart.tvalid, 1'b1);
        chk ("lb_tx_first", 96'(u_m_uart.tdata), 96'hA0);
        chk1("lb_ret_rdy", u_s_cipher.tready, 1'b0);
        chk1("lb_busy",    w_busy, 1'b1);
        got = 0;
        for (int c = 0; c < 80 && got < 12; c++) begin
            u_m_uart.tready = c[0];
            hs = u_m_uart.tvalid && u_m_uart.tready;
            b  = u_m_uart.tdata;
            tick();
            if (hs) begin
                eb = 8'hA0 + 8'(got);
                chk($sformatf("lb_byte%0d", got), 96'(b), 96'(eb));
                got++;
            end
        end
        u_m_uart.tready = 1'b0;
        chk("lb_count", 96'(got), 96'd12);
        tick();
        chk1("lb_tx_idle",  u_m_uart.tvalid, 1'b0);
        chk1("lb_ret_rdy2", u_s_cipher.tready, 1'b1);
        chk1("lb_busy2",    w_busy, 1'b0);

        // Key frame waits for three outstanding blocks to drain
        u_m_cipher.tready = 1'b1;
        send_frame(8'h45, 96'h101112131415161718191A1B);
        chk1("kw_issue_a", u_m_cipher.tvalid, 1'b1);
        tick();
        send_frame(8'h45, 96'h202122232425262728292A2B);
        chk1("kw_issue_b", u_m_cipher.tvalid, 1'b1);
        tick();
        return_result(96'hB0B1B2B3B4B5B6B7B8B9BABB);
        send_frame(8'h45, 96'h303132333435363738393A3B);
        chk1("kw_issue_c", u_m_cipher.tvalid, 1'b1);
        chk ("kw_issue_c_d", u_m_cipher.tdata, 96'h303132333435363738393A3B);
        tick();
        send_frame(8'h4B, 96'hFEDCBA9876543210A5A55A5A);
        tick();
        chk ("kw_key_old",  w_key, KEY_RST);
        chk1("kw_rx_rdy",   u_s_uart.tready, 1'b0);
        chk1("kw_busy",     w_busy, 1'b1);
        u_m_uart.tready = 1'b1;
        return_result(96'hC0C1C2C3C4C5C6C7C8C9CACB);
        chk ("kw_key_old2", w_key, KEY_RST);
        return_result(96'hD0D1D2D3D4D5D6D7D8D9DADB);
        repeat (11) tick();
        chk1("kw_ser_full", u_s_cipher.tready, 1'b0);
        chk ("kw_key_old3", w_key, KEY_RST);
        tick();
        chk1("kw_ser_empty", u_s_cipher.tready, 1'b1);
        chk ("kw_key_old4",  w_key, KEY_RST);
        chk1("kw_rx_rdy2",   u_s_uart.tready, 1'b0);
        tick();
        chk ("kw_key_new",  w_key, 96'hFEDCBA9876543210A5A55A5A);
        chk1("kw_rx_rdy3",  u_s_uart.tready, 1'b1);
        chk1("kw_busy2",    w_busy, 1'b0);

        // Issue throttle at two blocks in flight
        send_frame(8'h45, 96'h111111111111111111111111);
        chk1("thr_v1", u_m_cipher.tvalid, 1'b1);
        tick();
        send_frame(8'h45, 96'h222222222222222222222222);
        chk1("thr_v2", u_m_cipher.tvalid, 1'b1);
        tick();
        send_frame(8'h45, 96'h333333333333333333333333);
        chk1("thr_hold0", u_m_cipher.tvalid, 1'b0);
        repeat (4) tick();
        chk1("thr_hold1", u_m_cipher.tvalid, 1'b0);
        chk1("thr_rx_rdy", u_s_uart.tready, 1'b0);
        chk1("thr_busy", w_busy, 1'b1);
        return_result(96'hE0E1E2E3E4E5E6E7E8E9EAEB);
        chk1("thr_rel_v", u_m_cipher.tvalid, 1'b1);
        chk ("thr_rel_d", u_m_cipher.tdata, 96'h333333333333333333333333);
        tick();
        chk1("thr_done_v",   u_m_cipher.tvalid, 1'b0);
        chk1("thr_done_rdy", u_s_uart.tready, 1'b1);
        u_m_cipher.tready = 1'b0;
        repeat (14) tick();
        chk1("thr_tx_idle", u_m_uart.tvalid, 1'b0);

        // Partial frame timeout, then bad headers up to saturation
        send_byte(8'h45);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(i));
        end
        repeat (15) tick();
        chk1("to_busy_pre", w_busy, 1'b1);
        chk ("to_err_pre",  96'(w_err), 96'd0);
        tick();
        chk1("to_busy_post", w_busy, 1'b0);
        chk ("to_err_post",  96'(w_err), 96'd1);
        chk1("to_rx_rdy",    u_s_uart.tready, 1'b1);
        send_byte(8'h7F);
        chk ("bad_hdr_err", 96'(w_err), 96'd2);
        chk1("bad_hdr_busy", w_busy, 1'b0);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h00);
        end
        chk ("err_sat", 96'(w_err), 96'd255);

        // Reset in the middle of a frame with the serializer holding a block
        u_m_uart.tready = 1'b0;
        return_result(96'hF0F1F2F3F4F5F6F7F8F9FAFB);
        chk1("pre_rst_tx_v", u_m_uart.tvalid, 1'b1);
        send_byte(8'h45);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h55);
        end
        rst_n = 1'b0;
        tick();
        chk1("mrst_tx_v",     u_m_uart.tvalid, 1'b0);
        chk1("mrst_cipher_v", u_m_cipher.tvalid, 1'b0);
        chk1("mrst_rx_rdy",   u_s_uart.tready, 1'b0);
        chk1("mrst_ret_rdy",  u_s_cipher.tready, 1'b1);
        chk ("mrst_key",      w_key, KEY_RST);
        chk ("mrst_err",      96'(w_err), 96'd0);
        chk1("mrst_busy",     w_busy, 1'b0);
        rst_n = 1'b1;
        tick();
        send_frame(8'h45, 96'h0F1E2D3C4B5A69788796A5B4);
        chk1("post_v1", u_m_cipher.tvalid, 1'b1);
        chk ("post_d1", u_m_cipher.tdata, 96'h0F1E2D3C4B5A69788796A5B4);
        u_m_cipher.tready = 1'b1;
        tick();
        u_m_cipher.tready = 1'b0;
        send_frame(8'h45, 96'hFFEEDDCCBBAA998877665544);
        chk1("post_v2", u_m_cipher.tvalid, 1'b1);
        chk ("post_d2", u_m_cipher.tdata, 96'hFFEEDDCCBBAA998877665544);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
